// File: rtl/clkdiv_multi.sv
// clkdiv_multi: N-channel tick / 50%-duty square-wave divider with glitch-free divisor reload.
// Optional phase-sync input: define CLKDIV_PHASE_SYNC_EN to add the sync port.
module clkdiv_multi #(
   parameter int                NCH      = 2,
   parameter int                CW       = 20,
   parameter logic [NCH*CW-1:0] DIV_INIT = {20'd262144, 20'd2},
   localparam int               SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            mclk,
   input  logic            clr,
   input  logic            load,
   input  logic [SELW-1:0] load_sel,
   input  logic [CW-1:0]   load_val,
`ifdef CLKDIV_PHASE_SYNC_EN
   input  logic            sync,
`endif
   output logic [NCH-1:0]  tick,
   output logic [NCH-1:0]  sq,
   output logic [NCH-1:0]  pending
);

   logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NCH-1:0][CW-1:0] div_act_q, div_act_d;
   logic [NCH-1:0][CW-1:0] div_shd_q, div_shd_d;
   logic [NCH-1:0]         pend_q, pend_d;
   logic [NCH-1:0]         tick_q, tick_d;
   logic [NCH-1:0]         sq_q, sq_d;
   logic [NCH-1:0]         load_hit;
   logic [NCH-1:0]         apply;
   logic                   sync_w;

`ifdef CLKDIV_PHASE_SYNC_EN
   assign sync_w = sync;
`else
   assign sync_w = 1'b0;
`endif

   // Selects >= NCH never match any channel index, so out-of-range loads fall away.
   always_comb begin
      load_hit = '0;
      for (int i = 0; i < NCH; i++) begin
         load_hit[i] = load && (32'(load_sel) == i);
      end
   end

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves
      // a value unassigned and no latch is inferred.
      cnt_d     = cnt_q;
      div_act_d = div_act_q;
      div_shd_d = div_shd_q;
      pend_d    = pend_q;
      sq_d      = sq_q;
      tick_d    = '0;
      apply     = '0;
      for (int i = 0; i < NCH; i++) begin
         if (sync_w) begin
            cnt_d[i] = '0;
            sq_d[i]  = 1'b0;
            apply[i] = pend_q[i];
         end else if (div_act_q[i] == '0) begin
            // Halted: counter parked at 0, sq frozen; a pending shadow restarts it.
            cnt_d[i] = '0;
            apply[i] = pend_q[i];
         end else if (cnt_q[i] == div_act_q[i] - CW'(1)) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
            sq_d[i]   = ~sq_q[i];
            apply[i]  = pend_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end

         if (apply[i]) begin
            div_act_d[i] = div_shd_q[i];
            pend_d[i]    = 1'b0;
         end
         // A load landing on the apply edge wins: the fresh value stays pending.
         if (load_hit[i]) begin
            div_shd_d[i] = load_val;
            pend_d[i]    = 1'b1;
         end
      end
   end

   always_ff @(posedge mclk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (clr) begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]     <= '0;
            div_act_q[i] <= DIV_INIT[i*CW +: CW];
            div_shd_q[i] <= DIV_INIT[i*CW +: CW];
         end
         pend_q <= '0;
         tick_q <= '0;
         sq_q   <= '0;
      end else begin
         cnt_q     <= cnt_d;
         div_act_q <= div_act_d;
         div_shd_q <= div_shd_d;
         pend_q    <= pend_d;
         tick_q    <= tick_d;
         sq_q      <= sq_d;
      end
   end

   assign tick    = tick_q;
   assign sq      = sq_q;
   assign pending = pend_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: table-driven run on a 2-channel instance plus directed
// sequences (halt/restart, out-of-range select on a 3-channel instance, phase sync).
module tb_clkdiv_multi;

   localparam int CW = 8;

   logic          mclk;
   logic          clr;
   logic          load;
   logic [0:0]    load_sel;
   logic [CW-1:0] load_val;
   logic [1:0]    tick, sq, pending;

   logic          load3;
   logic [1:0]    load_sel3;
   logic [CW-1:0] load_val3;
   logic [2:0]    tick3, sq3, pending3;

`ifdef CLKDIV_PHASE_SYNC_EN
   logic          sync;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   clkdiv_multi #(.NCH(2), .CW(CW), .DIV_INIT({8'd5, 8'd2})) u_dut (
      .mclk     (mclk),
      .clr      (clr),
      .load     (load),
      .load_sel (load_sel),
      .load_val (load_val),
`ifdef CLKDIV_PHASE_SYNC_EN
      .sync     (sync),
`endif
      .tick     (tick),
      .sq       (sq),
      .pending  (pending)
   );

   clkdiv_multi #(.NCH(3), .CW(CW), .DIV_INIT({8'd3, 8'd5, 8'd2})) u_dut3 (
      .mclk     (mclk),
      .clr      (clr),
      .load     (load3),
      .load_sel (load_sel3),
      .load_val (load_val3),
`ifdef CLKDIV_PHASE_SYNC_EN
      .sync     (1'b0),
`endif
      .tick     (tick3),
      .sq       (sq3),
      .pending  (pending3)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   typedef struct {
      logic       clr;
      logic       ld;
      logic       sel;
      logic [7:0] val;
      logic [1:0] tick;
      logic [1:0] sq;
      logic [1:0] pend;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic c, input logic l, input logic s, input logic [7:0] v,
                      input logic [1:0] t, input logic [1:0] q, input logic [1:0] p);
      vec_t r;
      r.clr  = c;
      r.ld   = l;
      r.sel  = s;
      r.val  = v;
      r.tick = t;
      r.sq   = q;
      r.pend = p;
      vecs.push_back(r);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clr       = 1'b1;
      load      = 1'b0;
      load_sel  = '0;
      load_val  = '0;
      load3     = 1'b0;
      load_sel3 = '0;
      load_val3 = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
      sync      = 1'b0;
`endif

      // Each row: inputs before edge k, {ch1,ch0} outputs after edge k.
      // ch0 D=2, ch1 D=5; ch1 reloaded to 3 at edge 12; ch0 reloaded to 7 on its wrap at edge 26.
      add(1, 0, 0, 0, 2'b00, 2'b00, 2'b00);   // reset edge 1
      add(1, 0, 0, 0, 2'b00, 2'b00, 2'b00);   // reset edge 2
      add(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);   // 1
      add(0, 0, 0, 0, 2'b01, 2'b01, 2'b00);   // 2
      add(0, 0, 0, 0, 2'b00, 2'b01, 2'b00);   // 3
      add(0, 0, 0, 0, 2'b01, 2'b00, 2'b00);   // 4
      add(0, 0, 0, 0, 2'b10, 2'b10, 2'b00);   // 5
      add(0, 0, 0, 0, 2'b01, 2'b11, 2'b00);   // 6
      add(0, 0, 0, 0, 2'b00, 2'b11, 2'b00);   // 7
      add(0, 0, 0, 0, 2'b01, 2'b10, 2'b00);   // 8
      add(0, 0, 0, 0, 2'b00, 2'b10, 2'b00);   // 9
      add(0, 0, 0, 0, 2'b11, 2'b01, 2'b00);   // 10
      add(0, 0, 0, 0, 2'b00, 2'b01, 2'b00);   // 11
      add(0, 1, 1, 3, 2'b01, 2'b00, 2'b10);   // 12 load ch1=3 with cnt[1]=1
      add(0, 0, 0, 0, 2'b00, 2'b00, 2'b10);   // 13
      add(0, 0, 0, 0, 2'b01, 2'b01, 2'b10);   // 14
      add(0, 0, 0, 0, 2'b10, 2'b11, 2'b00);   // 15 ch1 wraps, applies 3
      add(0, 0, 0, 0, 2'b01, 2'b10, 2'b00);   // 16
      add(0, 0, 0, 0, 2'b00, 2'b10, 2'b00);   // 17
      add(0, 0, 0, 0, 2'b11, 2'b01, 2'b00);   // 18
      add(0, 0, 0, 0, 2'b00, 2'b01, 2'b00);   // 19
      add(0, 0, 0, 0, 2'b01, 2'b00, 2'b00);   // 20
      add(0, 0, 0, 0, 2'b10, 2'b10, 2'b00);   // 21
      add(0, 0, 0, 0, 2'b01, 2'b11, 2'b00);   // 22
      add(0, 0, 0, 0, 2'b00, 2'b11, 2'b00);   // 23
      add(0, 0, 0, 0, 2'b11, 2'b00, 2'b00);   // 24
      add(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);   // 25
      add(0, 1, 0, 7, 2'b01, 2'b01, 2'b01);   // 26 load ch0=7 on its wrap edge
      add(0, 0, 0, 0, 2'b10, 2'b11, 2'b01);   // 27
      add(0, 0, 0, 0, 2'b01, 2'b10, 2'b00);   // 28 last 2-cycle wrap, applies 7
      add(0, 0, 0, 0, 2'b00, 2'b10, 2'b00);   // 29
      add(0, 0, 0, 0, 2'b10, 2'b00, 2'b00);   // 30
      add(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);   // 31
      add(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);   // 32
      add(0, 0, 0, 0, 2'b10, 2'b10, 2'b00);   // 33
      add(0, 0, 0, 0, 2'b00, 2'b10, 2'b00);   // 34
      add(0, 0, 0, 0, 2'b01, 2'b11, 2'b00);   // 35 first 7-cycle tick
      add(0, 0, 0, 0, 2'b10, 2'b01, 2'b00);   // 36

      for (int i = 0; i < vecs.size(); i++) begin
         clr      = vecs[i].clr;
         load     = vecs[i].ld;
         load_sel = vecs[i].sel;
         load_val = vecs[i].val;
         step();
         check($sformatf("vec%0d_tick", i), 8'(tick), 8'(vecs[i].tick));
         check($sformatf("vec%0d_sq", i), 8'(sq), 8'(vecs[i].sq));
         check($sformatf("vec%0d_pend", i), 8'(pending), 8'(vecs[i].pend));
      end
      load = 1'b0;

      // Halt ch0 with a load of 0, then restart it with 4.
      clr = 1'b1;
      step();
      clr      = 1'b0;
      load     = 1'b1;
      load_sel = 1'b0;
      load_val = 8'd0;
      step();                                   // edge 1
      load = 1'b0;
      check("halt_pend_set", 8'(pending[0]), 8'd1);
      step();                                   // edge 2: wrap applies D=0
      check("halt_wrap_tick", 8'(tick[0]), 8'd1);
      check("halt_wrap_sq", 8'(sq[0]), 8'd1);
      check("halt_pend_clr", 8'(pending[0]), 8'd0);
      for (int k = 3; k <= 8; k++) begin
         step();
         check($sformatf("halted_tick_e%0d", k), 8'(tick[0]), 8'd0);
         check($sformatf("halted_sq_e%0d", k), 8'(sq[0]), 8'd1);
         check($sformatf("halt_ch1_tick_e%0d", k), 8'(tick[1]), (k % 5 == 0) ? 8'd1 : 8'd0);
      end
      load     = 1'b1;
      load_val = 8'd4;
      step();                                   // edge 9: captured only
      load = 1'b0;
      check("restart_pend_set", 8'(pending[0]), 8'd1);
      check("restart_tick_e9", 8'(tick[0]), 8'd0);
      step();                                   // edge 10: apply edge
      check("restart_pend_clr", 8'(pending[0]), 8'd0);
      check("restart_tick_e10", 8'(tick[0]), 8'd0);
      check("restart_ch1_tick_e10", 8'(tick[1]), 8'd1);
      for (int k = 11; k <= 13; k++) begin
         step();
         check($sformatf("restart_tick_e%0d", k), 8'(tick[0]), 8'd0);
      end
      step();                                   // edge 14: 4 edges after apply
      check("restart_tick_e14", 8'(tick[0]), 8'd1);
      check("restart_sq_e14", 8'(sq[0]), 8'd0);

      // Out-of-range select on the 3-channel instance (D = 2, 5, 3).
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         load3     = (k == 1);
         load_sel3 = 2'd3;
         load_val3 = 8'd1;
         step();
         check($sformatf("oor_pend_e%0d", k), 8'(pending3), 8'd0);
         check($sformatf("oor_tick_e%0d", k), 8'(tick3),
               8'({(k % 3 == 0), (k % 5 == 0), (k % 2 == 0)}));
      end
      load3 = 1'b0;
      check("oor_sq_e6", 8'(sq3), 8'(3'b011));

`ifdef CLKDIV_PHASE_SYNC_EN
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      step();
      step();                                   // edges 1..3
      sync = 1'b1;
      step();                                   // edge 4
      sync = 1'b0;
      check("sync_tick", 8'(tick), 8'(2'b00));
      check("sync_sq", 8'(sq), 8'(2'b00));
      for (int k = 5; k <= 9; k++) begin
         step();
         check($sformatf("sync_tick_e%0d", k), 8'(tick),
               8'({(k == 9), (k == 6 || k == 8)}));
      end
      load     = 1'b1;
      load_sel = 1'b1;
      load_val = 8'd3;
      step();                                   // edge 10
      check("sync_pre_pend", 8'(pending), 8'(2'b10));
      sync     = 1'b1;
      load_sel = 1'b0;
      load_val = 8'd6;
      step();                                   // edge 11: ch1 applies, ch0 captured
      sync = 1'b0;
      load = 1'b0;
      check("sync_apply_pend", 8'(pending), 8'(2'b01));
      check("sync_apply_sq", 8'(sq), 8'(2'b00));
      step();
      check("sync_apply_tick_e12", 8'(tick), 8'(2'b00));
      step();
      check("sync_apply_tick_e13", 8'(tick), 8'(2'b01));
      check("sync_apply_pend_e13", 8'(pending), 8'(2'b00));
      step();
      check("sync_apply_tick_e14", 8'(tick), 8'(2'b10));
      clr      = 1'b1;
      sync     = 1'b1;
      load     = 1'b1;
      load_sel = 1'b1;
      load_val = 8'd9;
      step();                                   // edge 15: clr beats sync and load
      clr  = 1'b0;
      sync = 1'b0;
      load = 1'b0;
      check("clr_sync_tick", 8'(tick), 8'(2'b00));
      check("clr_sync_sq", 8'(sq), 8'(2'b00));
      check("clr_sync_pend", 8'(pending), 8'(2'b00));
      for (int k = 16; k <= 20; k++) begin
         step();
         check($sformatf("clr_sync_tick_e%0d", k), 8'(tick),
               8'({(k == 20), (k == 17 || k == 19)}));
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
